// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit.
//   fetch_state_t : fetch FSM states (CHECK, FETCH, ERROR)
//   MISS_CNT_W    : width of the completed-fetch counter
//   ALIGN_MASK    : low PC bits that must be zero for a word-aligned fetch
package fetch_pkg;

  typedef enum logic [1:0] {
    CHECK = 2'd0,
    FETCH = 2'd1,
    ERROR = 2'd2
  } fetch_state_t;

  localparam int MISS_CNT_W = 16;

  localparam logic [1:0] ALIGN_MASK = 2'b11;

endpackage

// File: rtl/timeout_counter.sv
// Request timeout counter for the fetch unit.
//   clk     : clock, rising edge
//   rst     : asynchronous active-high reset
//   clr     : restart counting from zero (edge that launches a request)
//   en      : count this cycle (request outstanding, no ack)
//   expired : the count reaches TIMEOUT on the coming edge
module timeout_counter #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [7:0] count;
  logic [8:0] count_inc;

  assign count_inc = {1'b0, count} + 9'd1;

  // Flags the edge on which the count would step onto TIMEOUT, so a
  // request is abandoned after exactly TIMEOUT cycles high.
  assign expired = en && (count_inc == 9'(TIMEOUT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != 8'hFF)) begin
      count <= count_inc[7:0];
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit with a one-entry tagged instruction buffer.
//   clk, rst     : clock (rising edge), asynchronous active-high reset
//   pc           : current PC from the data path
//   instr        : buffered instruction word (always the buffer contents)
//   instr_valid  : instr is the word at pc
//   cpu_stall    : ~instr_valid, freezes the data path
//   imem_req     : registered memory request
//   imem_addr    : registered request address
//   imem_ack     : memory completion
//   imem_rdata   : read data, valid with imem_ack
//   imem_err     : bus error, qualified by imem_ack
//   fetch_err    : sticky error flag (bus error, timeout or misaligned PC)
//   miss_count   : completed memory fetches, saturating
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] pc,
  output logic [DATA_WIDTH-1:0] instr,
  output logic                  instr_valid,
  output logic                  cpu_stall,
  output logic                  imem_req,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic                  imem_ack,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  input  logic                  imem_err,
  output logic                  fetch_err,
  output logic [MISS_CNT_W-1:0] miss_count
);

  fetch_state_t          state, state_nxt;
  logic [ADDR_WIDTH-1:0] tag;
  logic [DATA_WIDTH-1:0] data;
  logic                  tag_ok;
  logic                  hit;
  logic                  misaligned;
  logic                  start_fetch;
  logic                  fetch_done;
  logic                  fetch_fail;
  logic                  align_fail;
  logic                  expired;
  logic                  tmo_en;

  assign hit        = tag_ok && (tag == pc);
  assign misaligned = |(pc[1:0] & ALIGN_MASK);

  // ERROR must force a stall even when a misaligned PC left tag_ok set.
  assign instr_valid = hit && (state != ERROR);
  assign cpu_stall   = ~instr_valid;
  assign instr       = data;

  // Counting stops on an ack cycle, so an ack always beats a timeout.
  assign tmo_en = (state == FETCH) && !imem_ack;

  timeout_counter #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clr    (start_fetch),
    .en     (tmo_en),
    .expired(expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= CHECK;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    start_fetch = 1'b0;
    fetch_done  = 1'b0;
    fetch_fail  = 1'b0;
    align_fail  = 1'b0;
    case (state)
      CHECK: begin
        if (hit) begin
          state_nxt = CHECK;
        end else if (misaligned) begin
          state_nxt  = ERROR;
          align_fail = 1'b1;
        end else begin
          state_nxt   = FETCH;
          start_fetch = 1'b1;
        end
      end
      FETCH: begin
        if (imem_ack && !imem_err) begin
          state_nxt  = CHECK;
          fetch_done = 1'b1;
        end else if (imem_ack || expired) begin
          state_nxt  = ERROR;
          fetch_fail = 1'b1;
        end
      end
      ERROR: begin
        state_nxt = ERROR;
      end
      default: begin
        state_nxt = CHECK;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      imem_req   <= 1'b0;
      imem_addr  <= '0;
      tag        <= '0;
      data       <= '0;
      tag_ok     <= 1'b0;
      fetch_err  <= 1'b0;
      miss_count <= '0;
    end else begin
      if (start_fetch) begin
        imem_req  <= 1'b1;
        imem_addr <= pc;
      end else if (fetch_done || fetch_fail) begin
        imem_req <= 1'b0;
      end

      // Tag with the address actually fetched; a PC that moved during the
      // fetch then simply misses on the next CHECK.
      if (fetch_done) begin
        tag    <= imem_addr;
        data   <= imem_rdata;
        tag_ok <= 1'b1;
        if (miss_count != {MISS_CNT_W{1'b1}}) begin
          miss_count <= miss_count + 1'b1;
        end
      end else if (fetch_fail) begin
        tag_ok <= 1'b0;
      end

      if (fetch_fail || align_fail) begin
        fetch_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: cold miss, hits, zero-wait memory,
// bus error, misaligned PC, timeout, ack-on-timeout and reset mid-fetch.
// Expected instruction words are queued when each fetch is launched and
// popped when the unit reports the instruction valid.
module tb_instr_fetch_unit;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int TMO = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] pc;
  logic [DW-1:0] instr;
  logic          instr_valid;
  logic          cpu_stall;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_ack;
  logic [DW-1:0] imem_rdata;
  logic          imem_err;
  logic          fetch_err;
  logic [15:0]   miss_count;

  int checks   = 0;
  int failures = 0;
  logic [DW-1:0] exp_q[$];

  always #5 clk = ~clk;

  instr_fetch_unit #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .TIMEOUT   (TMO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pc         (pc),
    .instr      (instr),
    .instr_valid(instr_valid),
    .cpu_stall  (cpu_stall),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .imem_err   (imem_err),
    .fetch_err  (fetch_err),
    .miss_count (miss_count)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    imem_ack = 1'b0;
    imem_err = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  // Launch a miss on addr; memory acks after w wait cycles with word.
  task automatic do_fetch(input string tag, input logic [AW-1:0] addr,
                          input logic [DW-1:0] word, input int w);
    int stall_cycles;
    int req_cycles;
    logic [DW-1:0] exp;
    stall_cycles = 0;
    req_cycles   = 0;
    pc = addr;
    #1;
    chk({tag, "_miss_stall"}, 64'(cpu_stall), 64'd1);
    if (cpu_stall) stall_cycles++;
    step();
    exp_q.push_back(word);
    chk({tag, "_req_addr"}, 64'(imem_addr), 64'(addr));
    for (int c = 0; c <= w; c++) begin
      if (cpu_stall) stall_cycles++;
      if (imem_req) req_cycles++;
      if (c == w) begin
        imem_ack   = 1'b1;
        imem_rdata = word;
      end
      step();
      imem_ack   = 1'b0;
      imem_rdata = '0;
    end
    chk({tag, "_req_cycles"}, 64'(req_cycles), 64'(w + 1));
    chk({tag, "_stall_cycles"}, 64'(stall_cycles), 64'(w + 2));
    chk({tag, "_valid"}, 64'(instr_valid), 64'd1);
    chk({tag, "_req_low"}, 64'(imem_req), 64'd0);
    if (exp_q.size() == 0) begin
      chk({tag, "_queue_empty"}, 64'd1, 64'd0);
    end else begin
      exp = exp_q.pop_front();
      chk({tag, "_instr"}, 64'(instr), 64'(exp));
    end
  endtask

  initial begin
    int n;
    int bad;
    rst        = 1'b1;
    pc         = '0;
    imem_ack   = 1'b0;
    imem_err   = 1'b0;
    imem_rdata = '0;
    #2;
    // reset values, asynchronous before any clock edge
    chk("rst_req", 64'(imem_req), 64'd0);
    chk("rst_addr", 64'(imem_addr), 64'd0);
    chk("rst_instr", 64'(instr), 64'd0);
    chk("rst_valid", 64'(instr_valid), 64'd0);
    chk("rst_stall", 64'(cpu_stall), 64'd1);
    chk("rst_err", 64'(fetch_err), 64'd0);
    chk("rst_miss", 64'(miss_count), 64'd0);
    do_reset();

    // cold miss, two wait cycles
    do_fetch("cold", 32'h0, 32'h2010_0005, 2);
    chk("cold_miss_count", 64'(miss_count), 64'd1);

    // hits for five cycles: no new request
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (!instr_valid || imem_req) bad++;
      step();
    end
    chk("hit_hold", 64'(bad), 64'd0);
    chk("hit_miss_count", 64'(miss_count), 64'd1);

    // new PC, zero-wait memory
    do_fetch("zw", 32'h4, 32'hA5A5_0004, 0);
    // back to 0: one-entry buffer must refetch
    do_fetch("refetch", 32'h0, 32'h2010_0005, 1);
    chk("refetch_miss_count", 64'(miss_count), 64'd3);
    chk("refetch_err", 64'(fetch_err), 64'd0);

    // bus error: absorbing until reset, stray ack ignored
    do_reset();
    pc = 32'h8;
    step();
    imem_ack = 1'b1;
    imem_err = 1'b1;
    step();
    imem_ack = 1'b0;
    imem_err = 1'b0;
    chk("buserr_flag", 64'(fetch_err), 64'd1);
    chk("buserr_req", 64'(imem_req), 64'd0);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (i == 5) imem_ack = 1'b1;
      if (i == 6) imem_ack = 1'b0;
      if (!cpu_stall || imem_req || !fetch_err) bad++;
      step();
    end
    chk("buserr_absorb", 64'(bad), 64'd0);
    chk("buserr_miss_count", 64'(miss_count), 64'd0);

    // misaligned PC: error without any request
    do_reset();
    chk("post_rst_err", 64'(fetch_err), 64'd0);
    pc = 32'h6;
    #1;
    chk("misalign_stall", 64'(cpu_stall), 64'd1);
    step();
    chk("misalign_err", 64'(fetch_err), 64'd1);
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      if (imem_req) bad++;
      step();
    end
    chk("misalign_no_req", 64'(bad), 64'd0);

    // timeout with no ack: request high exactly TMO cycles
    do_reset();
    pc = 32'h10;
    step();
    n = 0;
    while (imem_req && n < 12) begin
      n++;
      step();
    end
    chk("tmo_req_cycles", 64'(n), 64'(TMO));
    chk("tmo_err", 64'(fetch_err), 64'd1);
    chk("tmo_stall", 64'(cpu_stall), 64'd1);

    // ack in the last allowed cycle beats the timeout
    do_reset();
    do_fetch("tmo_ack", 32'h10, 32'h1234_5678, TMO - 1);
    chk("tmo_ack_err", 64'(fetch_err), 64'd0);

    // reset mid-fetch: request drops asynchronously, late ack ignored
    pc = 32'h20;
    step();
    chk("midrst_req_up", 64'(imem_req), 64'd1);
    rst = 1'b1;
    #1;
    chk("midrst_req_async", 64'(imem_req), 64'd0);
    pc = 32'h0;
    step();
    rst        = 1'b0;
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    step();
    imem_ack   = 1'b0;
    imem_rdata = '0;
    chk("midrst_late_ack_valid", 64'(instr_valid), 64'd0);
    chk("midrst_refetch_req", 64'(imem_req), 64'd1);
    chk("midrst_refetch_addr", 64'(imem_addr), 64'd0);
    chk("midrst_miss_count", 64'(miss_count), 64'd0);
    imem_ack   = 1'b1;
    imem_rdata = 32'h0BAD_F00D;
    step();
    imem_ack   = 1'b0;
    chk("midrst_valid", 64'(instr_valid), 64'd1);
    chk("midrst_instr", 64'(instr), 64'h0BAD_F00D);
    chk("midrst_final_count", 64'(miss_count), 64'd1);
    chk("midrst_err", 64'(fetch_err), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch stage directly upstream of the single-cycle data path. Takes the PC it produces, fetches the 32-bit word from a variable-latency instruction memory over a req/ack handshake, and presents the instruction with a valid flag. A one-entry tagged buffer makes repeated fetches of the same PC immediate. `cpu_stall` freezes the data path (PC register and register-file writes) until the instruction is valid.

## Interface
Parameters:
- `ADDR_WIDTH`, default 32: PC and memory address width.
- `DATA_WIDTH`, default 32: instruction width.
- `TIMEOUT`, default 15: maximum cycles `imem_req` may stay high without `imem_ack`; range 1..255.

Ports (one clock; reset is asynchronous and active-high):
- `clk`, in, 1: clock, rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `pc`, in, ADDR_WIDTH: current PC from the data path.
- `instr`, out, DATA_WIDTH: buffered instruction word.
- `instr_valid`, out, 1: `instr` is the word at `pc`.
- `cpu_stall`, out, 1: equal to `~instr_valid`.
- `imem_req`, out, 1: memory request, registered.
- `imem_addr`, out, ADDR_WIDTH: request address, registered.
- `imem_ack`, in, 1: memory completion.
- `imem_rdata`, in, DATA_WIDTH: read data, valid with `imem_ack`.
- `imem_err`, in, 1: bus error, qualified by `imem_ack`.
- `fetch_err`, out, 1: sticky error flag.
- `miss_count`, out, 16: number of completed memory fetches, saturating at 0xFFFF.

## Operation
- The buffer holds three fields: `tag` (ADDR_WIDTH), `data` (DATA_WIDTH) and `tag_ok` (1).
- A hit is `tag_ok && tag == pc`. On a hit, `instr_valid` is driven combinationally in the same cycle.
- The FSM has three states: CHECK, FETCH and ERROR.
- **CHECK:**
  - Hit: stay in CHECK.
  - `pc[1:0] != 0`: go to ERROR and set `fetch_err`. No request is issued.
  - Miss: go to FETCH. On the same edge, `imem_req`←1 and `imem_addr`←`pc`, and the timeout counter is cleared.
- **FETCH:**
  - `imem_req` stays high and `imem_addr` stays stable until `imem_ack` is sampled high.
  - `imem_ack && !imem_err`: `data`←`imem_rdata`, `tag`←`imem_addr`, `tag_ok`←1, `miss_count`+1 (saturating), `imem_req`←0, go to CHECK.
  - `imem_ack && imem_err`: `imem_req`←0, `tag_ok`←0, `fetch_err`←1, go to ERROR.
  - Timeout counter reaches `TIMEOUT` with no ack: same action as `imem_err`.
- **ERROR:** absorbing. `imem_req`=0, `cpu_stall`=1, `instr_valid`=0. Only `rst` exits this state.
- An `imem_ack` arriving outside FETCH is ignored.
- `pc` changing during FETCH is tolerated. The buffer is tagged with `imem_addr`, so the next CHECK mismatches and refetches.
- `instr` always drives `data`, even when `instr_valid`=0.

## Timing
- Reset values: `imem_req`=0, `imem_addr`=0, `instr`=0, `instr_valid`=0, `cpu_stall`=1, `fetch_err`=0, `miss_count`=0, `tag_ok`=0, state=CHECK.
- Hit latency: 0 cycles.
- Miss latency, where W is the number of cycles `imem_ack` lags `imem_req` (W=0 means ack in the first request cycle):
  - `imem_req` rises at edge 1 after the miss is seen.
  - The ack is sampled at edge 1+W.
  - `instr_valid` rises in the cycle after that edge.
  - Total stall: W+2 cycles.
- Timeout: with no ack, error is declared at the edge where `imem_req` has been high for `TIMEOUT` cycles.
- `rst` mid-FETCH drops `imem_req` immediately (asynchronously). A stale ack that arrives afterwards is ignored.
- Ack and timeout on the same edge: the ack wins.

## Structure
- Package `fetch_pkg` contains:
  - the state enum `fetch_state_t` {CHECK, FETCH, ERROR};
  - the constant `MISS_CNT_W`=16;
  - the alignment-mask constant.
- Sub-module `timeout_counter`: 8-bit, with inputs `clr` and `en`, output `expired` (count==`TIMEOUT`), and asynchronous `rst`.
- FSM, buffer and counters live in `instr_fetch_unit`.

## Test plan
- **Cold miss:** `rst` pulse, `pc`=0, memory acks 2 cycles after req with 0x20100005 → `imem_req` high for 3 cycles with `imem_addr`=0; `instr`=0x20100005 and `instr_valid`=1 the cycle after the ack; `miss_count`=1.
- **Hit, then new PC:** hold `pc`=0 for 5 cycles → `instr_valid` stays 1 and no new req. Then `pc`=4 → `cpu_stall`=1 in that same cycle, and req with `imem_addr`=4.
- **Zero-wait memory:** ack in the first req cycle → `imem_req` high for exactly 1 cycle; total stall is 2 cycles.
- **Errors:**
  - `imem_err` with ack → `fetch_err`=1, `imem_req`=0, `cpu_stall` stays 1 for 20 cycles until `rst`.
  - `pc`=0x6 → `fetch_err`=1 and no req issued.
- **Timeout:** `TIMEOUT`=4, ack never arrives → `imem_req` high for exactly 4 cycles, then `fetch_err`=1. An ack on the 4th cycle instead → normal completion, `fetch_err`=0.
- **Reset mid-fetch:** `rst` asserted during FETCH → `imem_req`=0 within the same cycle (asynchronous). A late ack has no effect, and `pc`=0 is refetched after reset release.
